// File: rtl/i2s_mic_receiver.sv
// ---------------------------------------------------------------------------
// i2s_mic_receiver
//
// I2S master receiver for a MEMS microphone. Derives the bit clock (SCK) and
// word select (WS) from the board clock and deserialises one selected slot
// of MSB-first serial data into a parallel sample with a one-cycle strobe.
//
// Ports:
//   clk          in   board clock (25 MHz)
//   rst          in   asynchronous, active-high reset
//   i2s_sck      out  I2S bit clock to the microphone
//   i2s_ws       out  I2S word select (0 = left slot, 1 = right slot)
//   i2s_sd       in   I2S serial data from the microphone
//   sample_out   out  last complete sample, two's complement
//   sample_valid out  one-clk pulse when sample_out updates
// ---------------------------------------------------------------------------
module i2s_mic_receiver #(
    parameter int CLK_DIV     = 6,
    parameter int SAMPLE_BITS = 16,
    parameter int CHANNEL     = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   i2s_sck,
    output logic                   i2s_ws,
    input  logic                   i2s_sd,
    output logic [SAMPLE_BITS-1:0] sample_out,
    output logic                   sample_valid
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [4:0]       LAST_POS = 5'(SAMPLE_BITS);
    localparam logic             SLOT_SEL = 1'(CHANNEL);

    // State
    logic [DIV_W-1:0]       div_r;
    logic                   sck_r;
    logic [5:0]             bit_cnt_r;
    logic [SAMPLE_BITS-1:0] shift_r;
    logic                   done_r;
    logic [SAMPLE_BITS-1:0] sample_r;
    logic                   valid_r;

    // Decoded events
    logic                   tick_s;
    logic                   rise_s;
    logic                   fall_s;
    logic [4:0]             pos_s;
    logic                   in_slot_s;
    logic                   capture_s;
    logic                   last_s;
    // One bit wider than the sample so the shift works even for 1-bit samples
    logic [SAMPLE_BITS:0]   shifted_s;

    // Decode SCK edge events and the slot position of the current bit
    always_comb begin
        tick_s    = (div_r == DIV_LAST);
        rise_s    = tick_s && !sck_r;
        fall_s    = tick_s && sck_r;
        pos_s     = bit_cnt_r[4:0];
        in_slot_s = (bit_cnt_r[5] == SLOT_SEL);
        // Position 0 is the trailing LSB slot of the previous word (standard
        // I2S one-bit delay); positions past SAMPLE_BITS are discarded.
        capture_s = rise_s && in_slot_s && (pos_s >= 5'd1) && (pos_s <= LAST_POS);
        last_s    = rise_s && in_slot_s && (pos_s == LAST_POS);
        shifted_s = {shift_r, i2s_sd};
    end

    // Clock divider: wraps every CLK_DIV cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r <= {DIV_W{1'b0}};
        end else if (tick_s) begin
            div_r <= {DIV_W{1'b0}};
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    // SCK generation: toggle on every divider wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_r <= 1'b0;
        end else if (tick_s) begin
            sck_r <= ~sck_r;
        end else begin
            sck_r <= sck_r;
        end
    end

    // Bit counter: advances on SCK falls so WS changes with a falling edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_r <= 6'd0;
        end else if (fall_s) begin
            bit_cnt_r <= bit_cnt_r + 6'd1;
        end else begin
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Shift register: SD sampled directly on SCK rise (mic launches on fall)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r <= {SAMPLE_BITS{1'b0}};
        end else if (capture_s) begin
            shift_r <= shifted_s[SAMPLE_BITS-1:0];
        end else begin
            shift_r <= shift_r;
        end
    end

    // Completion flag: set for the cycle after the last captured bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_r <= 1'b0;
        end else begin
            done_r <= last_s;
        end
    end

    // Output register and strobe: publish the full word once per frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_r <= {SAMPLE_BITS{1'b0}};
            valid_r  <= 1'b0;
        end else if (done_r) begin
            sample_r <= shift_r;
            valid_r  <= 1'b1;
        end else begin
            sample_r <= sample_r;
            valid_r  <= 1'b0;
        end
    end

    assign i2s_sck      = sck_r;
    assign i2s_ws       = bit_cnt_r[5];
    assign sample_out   = sample_r;
    assign sample_valid = valid_r;

endmodule

// File: tb/tb_i2s_mic_receiver.sv
// ---------------------------------------------------------------------------
// tb_i2s_mic_receiver
//
// Drives two receivers (left-slot and right-slot) from one behavioural I2S
// microphone model that follows WS/SCK like a real mic. Expected samples and
// strobe timing come from the frame arithmetic of the protocol.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2s_mic_receiver;

    localparam int CLK_DIV = 6;
    localparam int SB      = 16;
    localparam int FRAME   = 128 * CLK_DIV;       // clk cycles per frame
    localparam int HALF_WS = 64 * CLK_DIV;        // clk cycles per WS level

    typedef struct {
        int        cyc;
        logic [15:0] val;
    } ev_t;

    logic        clk;
    logic        rst;
    logic        sd;
    logic        sck0, ws0, valid0;
    logic        sck1, ws1, valid1;
    logic [15:0] out0, out1;

    int          cyc;
    int          n_checks;
    int          n_fail;
    int          hold_err;
    ev_t         q0[$];
    ev_t         q1[$];
    logic [15:0] left_q[$];
    logic [15:0] right_q[$];
    bit          stuck;

    i2s_mic_receiver #(.CLK_DIV(CLK_DIV), .SAMPLE_BITS(SB), .CHANNEL(0)) dut_left (
        .clk(clk), .rst(rst), .i2s_sck(sck0), .i2s_ws(ws0), .i2s_sd(sd),
        .sample_out(out0), .sample_valid(valid0)
    );

    i2s_mic_receiver #(.CLK_DIV(CLK_DIV), .SAMPLE_BITS(SB), .CHANNEL(1)) dut_right (
        .clk(clk), .rst(rst), .i2s_sck(sck1), .i2s_ws(ws1), .i2s_sd(sd),
        .sample_out(out1), .sample_valid(valid1)
    );

    // 25 MHz board clock
    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    // Cycle index since reset release (edge 1 is the first edge after release)
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Microphone model: counts SCK falls since the last WS change, drives the
    // MSB one SCK after WS changes, then pads with 1s (24-bit style mic).
    initial begin : mic
        int          mp;
        logic        prev_ws;
        logic [15:0] cur;
        mp = 0; prev_ws = 1'b0; cur = 16'h0000; sd = 1'b1;
        forever begin
            @(negedge sck0 or posedge rst);
            if (rst) begin
                mp = 0; prev_ws = 1'b0; sd = 1'b1;
            end else begin
                #1;
                if (ws0 !== prev_ws) mp = 0;
                else                 mp = mp + 1;
                prev_ws = ws0;
                if (mp == 1) begin
                    if (ws0 == 1'b0) begin
                        if (left_q.size() > 1) cur = left_q.pop_front();
                        else if (left_q.size() == 1) cur = left_q[0];
                        else cur = 16'h0000;
                    end else begin
                        if (right_q.size() > 1) cur = right_q.pop_front();
                        else if (right_q.size() == 1) cur = right_q[0];
                        else cur = 16'h0000;
                    end
                end
                if (stuck)                   sd = 1'b0;
                else if (mp >= 1 && mp <= SB) sd = cur[SB - mp];
                else                          sd = 1'b1;
            end
        end
    end

    // Strobe recorder and hold-stability watcher, sampled away from posedge
    initial begin : monitor
        logic [15:0] p0, p1;
        p0 = 16'h0000; p1 = 16'h0000;
        forever begin
            @(negedge clk);
            if (rst) begin
                p0 = 16'h0000; p1 = 16'h0000;
            end else begin
                if (valid0) q0.push_back('{cyc, out0});
                else if (out0 !== p0) hold_err++;
                if (valid1) q1.push_back('{cyc, out1});
                else if (out1 !== p1) hold_err++;
                p0 = out0; p1 = out1;
            end
        end
    end

    // First strobe cycle for a slot: one clk after the rise at position SB
    function automatic int first_valid(input int ch);
        return (2 * (32 * ch + SB) + 1) * CLK_DIV + 1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        stuck = 1'b0;
        q0.delete();
        q1.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_pulses(input int n0, input int n1, input int budget, output bit ok);
        int k;
        k = 0;
        while ((q0.size() < n0 || q1.size() < n1) && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (q0.size() >= n0) && (q1.size() >= n1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks += 8;
        if (sck0 !== 1'b0)     begin n_fail++; $display("FAIL reset_sck0: got %b expected 0", sck0); end
        if (ws0 !== 1'b0)      begin n_fail++; $display("FAIL reset_ws0: got %b expected 0", ws0); end
        if (out0 !== 16'h0)    begin n_fail++; $display("FAIL reset_out0: got %h expected 0000", out0); end
        if (valid0 !== 1'b0)   begin n_fail++; $display("FAIL reset_valid0: got %b expected 0", valid0); end
        if (sck1 !== 1'b0)     begin n_fail++; $display("FAIL reset_sck1: got %b expected 0", sck1); end
        if (ws1 !== 1'b0)      begin n_fail++; $display("FAIL reset_ws1: got %b expected 0", ws1); end
        if (out1 !== 16'h0)    begin n_fail++; $display("FAIL reset_out1: got %h expected 0000", out1); end
        if (valid1 !== 1'b0)   begin n_fail++; $display("FAIL reset_valid1: got %b expected 0", valid1); end
    endtask

    task automatic test_clock_gen();
        int   last_t, falls, last_ws_t, nw, bad_half;
        logic ps, pw;
        left_q = {16'h0000}; right_q = {16'h0000};
        do_reset();
        ps = 1'b0; pw = 1'b0; last_t = 0; falls = 0; last_ws_t = 0; nw = 0; bad_half = 0;
        repeat (1600) begin
            @(negedge clk);
            if (sck0 !== ps) begin
                n_checks++;
                if (cyc - last_t != CLK_DIV) begin
                    n_fail++;
                    $display("FAIL sck_half_period: got %0d clk expected %0d at cyc %0d", cyc - last_t, CLK_DIV, cyc);
                end
                last_t = cyc;
                if (ps == 1'b1) falls++;
            end
            if (ws0 !== pw) begin
                nw++;
                n_checks += 2;
                if (!(ps == 1'b1 && sck0 == 1'b0)) begin
                    n_fail++;
                    $display("FAIL ws_on_fall: sck %b->%b expected 1->0 at cyc %0d", ps, sck0, cyc);
                end
                if (falls != 32) begin
                    n_fail++;
                    $display("FAIL ws_fall_count: got %0d expected 32", falls);
                end
                n_checks++;
                if (cyc - last_ws_t != HALF_WS) begin
                    n_fail++;
                    $display("FAIL ws_half_period: got %0d expected %0d", cyc - last_ws_t, HALF_WS);
                end
                falls = 0;
                last_ws_t = cyc;
            end
            ps = sck0; pw = ws0;
        end
        n_checks++;
        if (nw != 4) begin n_fail++; $display("FAIL ws_toggles: got %0d expected 4", nw); end
    endtask

    task automatic test_first_sample();
        bit          ok;
        logic [15:0] r;
        r = 16'($urandom);
        left_q = {16'hA5C3}; right_q = {r};
        do_reset();
        wait_pulses(2, 1, 3 * FRAME, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL first_timeout: got %0d/%0d pulses expected 2/1", q0.size(), q1.size());
        end else begin
            n_checks += 5;
            if (q0[0].cyc != first_valid(0)) begin n_fail++; $display("FAIL first_left_time: got %0d expected %0d", q0[0].cyc, first_valid(0)); end
            if (q0[0].val !== 16'hA5C3)      begin n_fail++; $display("FAIL first_left_val: got %h expected a5c3", q0[0].val); end
            if (q0[1].cyc != first_valid(0) + FRAME) begin n_fail++; $display("FAIL valid_width: next pulse at %0d expected %0d", q0[1].cyc, first_valid(0) + FRAME); end
            if (q1[0].cyc != first_valid(1)) begin n_fail++; $display("FAIL first_right_time: got %0d expected %0d", q1[0].cyc, first_valid(1)); end
            if (q1[0].val !== r)             begin n_fail++; $display("FAIL first_right_val: got %h expected %h", q1[0].val, r); end
        end
    endtask

    task automatic test_channel_select();
        bit ok;
        left_q = {16'h1234}; right_q = {16'hFFFF};
        do_reset();
        wait_pulses(3, 3, 5 * FRAME, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL chan_timeout: got %0d/%0d pulses expected 3/3", q0.size(), q1.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks += 4;
                if (q0[i].val !== 16'h1234) begin n_fail++; $display("FAIL chan_left_val[%0d]: got %h expected 1234", i, q0[i].val); end
                if (q1[i].val !== 16'hFFFF) begin n_fail++; $display("FAIL chan_right_val[%0d]: got %h expected ffff", i, q1[i].val); end
                if (q0[i].cyc != first_valid(0) + i * FRAME) begin n_fail++; $display("FAIL chan_left_time[%0d]: got %0d expected %0d", i, q0[i].cyc, first_valid(0) + i * FRAME); end
                if (q1[i].cyc != first_valid(1) + i * FRAME) begin n_fail++; $display("FAIL chan_right_time[%0d]: got %0d expected %0d", i, q1[i].cyc, first_valid(1) + i * FRAME); end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit          ok;
        int          h0;
        logic [15:0] exp_l[4];
        logic [15:0] exp_r[4];
        exp_l[0] = 16'h8000; exp_l[1] = 16'h7FFF; exp_l[2] = 16'h0001; exp_l[3] = 16'($urandom);
        for (int i = 0; i < 4; i++) exp_r[i] = 16'($urandom);
        left_q.delete(); right_q.delete();
        for (int i = 0; i < 4; i++) begin
            left_q.push_back(exp_l[i]);
            right_q.push_back(exp_r[i]);
        end
        do_reset();
        h0 = hold_err;
        wait_pulses(4, 4, 6 * FRAME, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b2b_timeout: got %0d/%0d pulses expected 4/4", q0.size(), q1.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks += 2;
                if (q0[i].val !== exp_l[i]) begin n_fail++; $display("FAIL b2b_left[%0d]: got %h expected %h", i, q0[i].val, exp_l[i]); end
                if (q1[i].val !== exp_r[i]) begin n_fail++; $display("FAIL b2b_right[%0d]: got %h expected %h", i, q1[i].val, exp_r[i]); end
            end
        end
        n_checks++;
        if (hold_err != h0) begin n_fail++; $display("FAIL b2b_hold: got %0d changes expected 0", hold_err - h0); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        left_q = {16'h5555}; right_q = {16'h3333};
        do_reset();
        // Rise at position 8 of the left slot is edge 17*CLK_DIV
        while (cyc < 17 * CLK_DIV + 3) @(negedge clk);
        #5 rst = 1'b1;
        #1;
        n_checks += 4;
        if (sck0 !== 1'b0)   begin n_fail++; $display("FAIL mid_sck: got %b expected 0", sck0); end
        if (ws0 !== 1'b0)    begin n_fail++; $display("FAIL mid_ws: got %b expected 0", ws0); end
        if (out0 !== 16'h0)  begin n_fail++; $display("FAIL mid_out: got %h expected 0000", out0); end
        if (valid0 !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", valid0); end
        repeat (2 * FRAME) @(negedge clk);
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL mid_no_pulse: got %0d/%0d pulses expected 0/0", q0.size(), q1.size());
        end
        left_q = {16'h0F0F}; right_q = {16'h3333};
        do_reset();
        wait_pulses(1, 0, 2 * FRAME, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL mid_timeout: got %0d pulses expected 1", q0.size());
        end else begin
            n_checks += 2;
            if (q0[0].val !== 16'h0F0F)      begin n_fail++; $display("FAIL mid_after_val: got %h expected 0f0f", q0[0].val); end
            if (q0[0].cyc != first_valid(0)) begin n_fail++; $display("FAIL mid_after_time: got %0d expected %0d", q0[0].cyc, first_valid(0)); end
        end
    endtask

    task automatic test_stuck_zero();
        bit ok;
        left_q = {16'hBEEF}; right_q = {16'h1111};
        do_reset();
        wait_pulses(1, 0, 2 * FRAME, ok);
        n_checks++;
        if (!ok || q0[0].val !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL stuck_first: got %0d pulses expected 1 with beef", q0.size());
        end
        stuck = 1'b1;
        wait_pulses(2, 0, 2 * FRAME, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL stuck_timeout: got %0d pulses expected 2", q0.size());
        end else begin
            n_checks += 2;
            if (q0[1].val !== 16'h0000) begin n_fail++; $display("FAIL stuck_val: got %h expected 0000", q0[1].val); end
            if (q0[1].cyc != q0[0].cyc + FRAME) begin n_fail++; $display("FAIL stuck_time: got %0d expected %0d", q0[1].cyc, q0[0].cyc + FRAME); end
            repeat (FRAME - 60) @(negedge clk);
            n_checks++;
            if (q0.size() != 2) begin n_fail++; $display("FAIL stuck_extra: got %0d pulses expected 2", q0.size()); end
        end
    endtask

    task automatic test_random();
        bit          ok;
        logic [15:0] exp_l[6];
        logic [15:0] exp_r[6];
        left_q.delete(); right_q.delete();
        for (int i = 0; i < 6; i++) begin
            exp_l[i] = 16'($urandom);
            exp_r[i] = 16'($urandom);
            left_q.push_back(exp_l[i]);
            right_q.push_back(exp_r[i]);
        end
        do_reset();
        wait_pulses(6, 6, 8 * FRAME, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rand_timeout: got %0d/%0d pulses expected 6/6", q0.size(), q1.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks += 2;
                if (q0[i].val !== exp_l[i]) begin n_fail++; $display("FAIL rand_left[%0d]: got %h expected %h", i, q0[i].val, exp_l[i]); end
                if (q1[i].val !== exp_r[i]) begin n_fail++; $display("FAIL rand_right[%0d]: got %h expected %h", i, q1[i].val, exp_r[i]); end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        stuck = 1'b0;
        n_checks = 0;
        n_fail = 0;
        hold_err = 0;
        test_reset();
        test_clock_gen();
        test_first_sample();
        test_channel_select();
        test_back_to_back();
        test_reset_mid();
        test_stuck_zero();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
